// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - FSM state type and constant helpers for code_lock
package code_lock_pkg;

`include "code_lock_defs.vh"

    typedef enum logic [1:0] {
        S_IDLE    = CL_ST_IDLE,
        S_ENTER   = CL_ST_ENTER,
        S_OPEN    = CL_ST_OPEN,
        S_LOCKOUT = CL_ST_LOCKOUT
    } state_t;

    function automatic int cl_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/code_lock_defs.vh
// rtl/code_lock_defs.vh - state encodings and width helpers shared by code_lock sources
`ifndef CODE_LOCK_DEFS_VH
`define CODE_LOCK_DEFS_VH

localparam logic [1:0] CL_ST_IDLE    = 2'd0;
localparam logic [1:0] CL_ST_ENTER   = 2'd1;
localparam logic [1:0] CL_ST_OPEN    = 2'd2;
localparam logic [1:0] CL_ST_LOCKOUT = 2'd3;

// Width of a counter that must hold the value n.
`define CL_FAIL_W(mf) $clog2((mf) + 1)
`define CL_PROG_W(cl) $clog2((cl) + 1)

`endif

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with terminal-count strobe
// Ports: i_clk/i_reset (sync, active-high), i_load/i_load_val start a count,
//        i_en qualifies o_done, which is high in the cycle the count reads zero.
module lock_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loading N-1 gives exactly N enabled cycles, the last of which strobes done.
    assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/code_lock.sv
// rtl/code_lock.sv - parametrised sequence-entry lock with open window and lockout
// Ports: clk/reset (sync, active-high); a/a_valid symbol strobe; lock_req and
//        code_load/code_in act only while open; unlock, locked_out, fail_cnt and
//        progress are registered status outputs.
`include "code_lock_defs.vh"

module code_lock
    import code_lock_pkg::*;
#(
    parameter int                           SYM_W        = 2,
    parameter int                           CODE_LEN     = 2,
    parameter logic [CODE_LEN*SYM_W-1:0]    DEFAULT_CODE = 4'b0111,
    parameter int                           MAX_FAIL     = 3,
    parameter int                           OPEN_CYC     = 8,
    parameter int                           LOCKOUT_CYC  = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [SYM_W-1:0]                      a,
    input  logic                                  a_valid,
    input  logic                                  lock_req,
    input  logic                                  code_load,
    input  logic [CODE_LEN*SYM_W-1:0]             code_in,
    output logic                                  unlock,
    output logic                                  locked_out,
    output logic [`CL_FAIL_W(MAX_FAIL)-1:0]       fail_cnt,
    output logic [`CL_PROG_W(CODE_LEN)-1:0]       progress
);

    localparam int FW = `CL_FAIL_W(MAX_FAIL);
    localparam int PW = `CL_PROG_W(CODE_LEN);
    localparam int TW = $clog2(cl_max(OPEN_CYC, LOCKOUT_CYC) + 1);

    state_t                      r_state,    w_state_nx;
    logic [CODE_LEN*SYM_W-1:0]   r_code,     w_code_nx;
    logic [PW-1:0]               r_progress, w_progress_nx;
    logic                        r_mismatch, w_mismatch_nx;
    logic [FW-1:0]               r_fail,     w_fail_nx;
    logic                        r_unlock;
    logic                        r_locked_out;

    logic [SYM_W-1:0]            w_sym_exp;
    logic                        w_miss;
    logic                        w_last;
    logic                        w_tmr_load;
    logic [TW-1:0]               w_tmr_val;
    logic                        w_tmr_en;
    logic                        w_tmr_done;

    // Expected symbol for the current position in the attempt.
    always_comb begin
        w_sym_exp = '0;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (r_progress == PW'(k)) begin
                w_sym_exp = r_code[k*SYM_W +: SYM_W];
            end
        end
    end

    // Sticky: one bad symbol spoils the attempt, but all symbols are still consumed.
    assign w_miss   = r_mismatch | (a != w_sym_exp);
    assign w_last   = (r_progress == PW'(CODE_LEN - 1));
    assign w_tmr_en = (r_state == S_OPEN) || (r_state == S_LOCKOUT);

    lock_timer #(
        .W(TW)
    ) u_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_code_nx     = r_code;
        w_progress_nx = r_progress;
        w_mismatch_nx = r_mismatch;
        w_fail_nx     = r_fail;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        case (r_state)
            S_IDLE, S_ENTER: begin
                if (a_valid) begin
                    if (w_last) begin
                        w_progress_nx = '0;
                        w_mismatch_nx = 1'b0;
                        if (!w_miss) begin
                            w_state_nx = S_OPEN;
                            w_fail_nx  = '0;
                            w_tmr_load = 1'b1;
                            w_tmr_val  = TW'(OPEN_CYC - 1);
                        end else if (int'(r_fail) + 1 < MAX_FAIL) begin
                            w_state_nx = S_IDLE;
                            w_fail_nx  = r_fail + 1'b1;
                        end else begin
                            w_state_nx = S_LOCKOUT;
                            w_fail_nx  = FW'(MAX_FAIL);
                            w_tmr_load = 1'b1;
                            w_tmr_val  = TW'(LOCKOUT_CYC - 1);
                        end
                    end else begin
                        w_state_nx    = S_ENTER;
                        w_progress_nx = r_progress + 1'b1;
                        w_mismatch_nx = w_miss;
                    end
                end
            end
            S_OPEN: begin
                // A load and a relock in the same cycle both take effect.
                if (code_load) begin
                    w_code_nx = code_in;
                end
                if (lock_req || w_tmr_done) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (w_tmr_done) begin
                    w_state_nx = S_IDLE;
                    w_fail_nx  = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_code       <= DEFAULT_CODE;
            r_progress   <= '0;
            r_mismatch   <= 1'b0;
            r_fail       <= '0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_code       <= w_code_nx;
            r_progress   <= w_progress_nx;
            r_mismatch   <= w_mismatch_nx;
            r_fail       <= w_fail_nx;
            r_unlock     <= (w_state_nx == S_OPEN);
            r_locked_out <= (w_state_nx == S_LOCKOUT);
        end
    end

    assign unlock     = r_unlock;
    assign locked_out = r_locked_out;
    assign fail_cnt   = r_fail;
    assign progress   = r_progress;

endmodule

// File: tb/tb_code_lock.sv
// tb/tb_code_lock.sv - scoreboard testbench for code_lock
module tb_code_lock;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] a = 2'b00;
    logic       a_valid = 1'b0;
    logic       lock_req = 1'b0;
    logic       code_load = 1'b0;
    logic [3:0] code_in = 4'b0000;
    logic       unlock;
    logic       locked_out;
    logic [1:0] fail_cnt;
    logic [1:0] progress;

    typedef struct {
        logic       u;
        logic       lo;
        logic [1:0] f;
        logic [1:0] p;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    code_lock dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .a_valid    (a_valid),
        .lock_req   (lock_req),
        .code_load  (code_load),
        .code_in    (code_in),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .progress   (progress)
    );

    // Monitor: every expectation belongs to the outputs after one clock edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            n_chk++;
            if (unlock === e_mon.u && locked_out === e_mon.lo &&
                fail_cnt === e_mon.f && progress === e_mon.p) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got unlock=%0b locked_out=%0b fail_cnt=%0d progress=%0d, need unlock=%0b locked_out=%0b fail_cnt=%0d progress=%0d",
                         e_mon.nm, unlock, locked_out, fail_cnt, progress,
                         e_mon.u, e_mon.lo, e_mon.f, e_mon.p);
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic lr, input logic cl, input logic [3:0] ci,
                        input logic eu, input logic elo, input logic [1:0] ef,
                        input logic [1:0] ep, input string nm);
        reset     = r;
        a_valid   = v;
        a         = s;
        lock_req  = lr;
        code_load = cl;
        code_in   = ci;
        @(posedge clk);
        q.push_back('{eu, elo, ef, ep, nm});
        #1;
        reset     = 1'b0;
        a_valid   = 1'b0;
        lock_req  = 1'b0;
        code_load = 1'b0;
    endtask

    task automatic sym(input logic [1:0] s, input logic eu, input logic elo,
                       input logic [1:0] ef, input logic [1:0] ep, input string nm);
        step(1'b0, 1'b1, s, 1'b0, 1'b0, 4'b0000, eu, elo, ef, ep, nm);
    endtask

    task automatic idle(input int n, input logic eu, input logic elo,
                        input logic [1:0] ef, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, eu, elo, ef, 2'd0, nm);
        end
    endtask

    task automatic relock(input string nm);
        step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, "reset0");
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, "reset1");

        // Correct code opens for exactly 8 cycles
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "open_s0");
        sym(2'b01, 1'b1, 1'b0, 2'd0, 2'd0, "open_s1");
        idle(7, 1'b1, 1'b0, 2'd0, "open_hold");
        idle(1, 1'b0, 1'b0, 2'd0, "open_expire");

        // One wrong attempt, then a correct one clears fail_cnt
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "bad_s0");
        sym(2'b10, 1'b0, 1'b0, 2'd1, 2'd0, "bad_s1");
        sym(2'b11, 1'b0, 1'b0, 2'd1, 2'd1, "good_after_bad_s0");
        sym(2'b01, 1'b1, 1'b0, 2'd0, 2'd0, "good_after_bad_s1");
        relock("relock1");

        // Three wrong attempts -> 16-cycle lockout
        sym(2'b00, 1'b0, 1'b0, 2'd0, 2'd1, "w1a");
        sym(2'b00, 1'b0, 1'b0, 2'd1, 2'd0, "w1b");
        sym(2'b00, 1'b0, 1'b0, 2'd1, 2'd1, "w2a");
        sym(2'b00, 1'b0, 1'b0, 2'd2, 2'd0, "w2b");
        sym(2'b00, 1'b0, 1'b0, 2'd2, 2'd1, "w3a");
        sym(2'b00, 1'b0, 1'b1, 2'd3, 2'd0, "w3b_lockout");
        sym(2'b11, 1'b0, 1'b1, 2'd3, 2'd0, "lockout_ign0");
        sym(2'b01, 1'b0, 1'b1, 2'd3, 2'd0, "lockout_ign1");
        idle(13, 1'b0, 1'b1, 2'd3, "lockout_hold");
        // Symbol on the expiry cycle is dropped
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd0, "lockout_expire");
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "post_lock_s0");
        sym(2'b01, 1'b1, 1'b0, 2'd0, 2'd0, "post_lock_s1");

        // Load new code and relock in the same OPEN cycle
        step(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 2'd0, "load_relock");
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "oldcode_s0");
        sym(2'b01, 1'b0, 1'b0, 2'd1, 2'd0, "oldcode_s1");
        sym(2'b00, 1'b0, 1'b0, 2'd1, 2'd1, "newcode_s0");
        sym(2'b10, 1'b1, 1'b0, 2'd0, 2'd0, "newcode_s1");
        relock("relock2");

        // code_load in IDLE is ignored
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 2'd0, 2'd0, "idle_load");
        sym(2'b00, 1'b0, 1'b0, 2'd0, 2'd1, "keepcode_s0");
        sym(2'b10, 1'b1, 1'b0, 2'd0, 2'd0, "keepcode_s1");
        relock("relock3");

        // Reset mid-lockout restores the default code
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "x1a");
        sym(2'b11, 1'b0, 1'b0, 2'd1, 2'd0, "x1b");
        sym(2'b11, 1'b0, 1'b0, 2'd1, 2'd1, "x2a");
        sym(2'b11, 1'b0, 1'b0, 2'd2, 2'd0, "x2b");
        sym(2'b11, 1'b0, 1'b0, 2'd2, 2'd1, "x3a");
        sym(2'b11, 1'b0, 1'b1, 2'd3, 2'd0, "x3b_lockout");
        idle(3, 1'b0, 1'b1, 2'd3, "x_lock_hold");
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, "reset_mid_lock");
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "default_s0");
        sym(2'b01, 1'b1, 1'b0, 2'd0, 2'd0, "default_s1");
        relock("relock4");

        // a_valid held two cycles: second symbol lands in OPEN and is ignored
        sym(2'b11, 1'b0, 1'b0, 2'd0, 2'd1, "held_s0");
        sym(2'b01, 1'b1, 1'b0, 2'd0, 2'd0, "held_s1");
        sym(2'b01, 1'b1, 1'b0, 2'd0, 2'd0, "held_ignored");
        idle(6, 1'b1, 1'b0, 2'd0, "held_open");
        idle(1, 1'b0, 1'b0, 2'd0, "held_expire");

        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, need 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
